// File: rtl/testreg_uart_reporter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : testreg_uart_reporter                                        |
// | Description : Watches the test-register TEST_PROGRESS / TEST_PASS /        |
// |               TEST_FAIL values and reports them as 15-byte ASCII lines     |
// |               ("PROG "/"PASS "/"FAIL " + 8 hex digits + CR LF) on an 8N1   |
// |               UART transmit pin.                                           |
// | Ports       : clk           - system clock, rising edge                    |
// |               rst_n         - asynchronous active-low reset                |
// |               test_progress - TEST_PROGRESS value (change => PROG line)    |
// |               test_pass     - TEST_PASS value (nonzero => PASS line)       |
// |               test_fail     - TEST_FAIL value (nonzero => FAIL line)       |
// |               uart_tx       - serial output, idle high                     |
// |               busy          - high while a message is being sent           |
// |               done          - sticky, set when PASS/FAIL is launched       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module testreg_uart_reporter #(
  parameter int CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] test_progress,
  input  logic [31:0] test_pass,
  input  logic [31:0] test_fail,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    LAST_BYTE = 4'd14;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
  typedef enum logic [1:0] {MSG_PROG, MSG_PASS, MSG_FAIL} msg_t;

  state_t        state_q, state_d;
  msg_t          msg_q,   msg_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    bit_q,   bit_d;
  logic [3:0]    byte_q,  byte_d;
  logic          tx_q,    tx_d;
  logic [31:0]   snap_q,  snap_d;
  logic [31:0]   prev_q,  prev_d;
  logic          pend_q,  pend_d;
  logic          done_q,  done_d;
  logic          init_q,  init_d;

  logic [39:0]   tag;
  logic [7:0]    tag_char;
  logic [3:0]    nib;
  logic [7:0]    hex_char;
  logic [7:0]    cur_byte;
  logic [2:0]    bit_nxt;
  logic          start;

  // Character generation for the byte currently on the wire.
  always_comb begin
    case (msg_q)
      MSG_PASS: tag = "PASS ";
      MSG_FAIL: tag = "FAIL ";
      default:  tag = "PROG ";
    endcase
  end

  // Bytes 0..4: tag characters, leftmost character first.
  assign tag_char = 8'(tag >> {(3'd4 - byte_q[2:0]), 3'b000});
  // Bytes 5..12: snapshot nibbles, most significant first.
  assign nib      = 4'(snap_q >> {(4'd12 - byte_q), 2'b00});
  assign hex_char = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});

  always_comb begin
    if (byte_q < 4'd5)       cur_byte = tag_char;
    else if (byte_q < 4'd13) cur_byte = hex_char;
    else if (byte_q == 4'd13) cur_byte = 8'h0D;
    else                     cur_byte = 8'h0A;
  end

  assign bit_nxt = bit_q + 3'd1;

  // tx_d always carries the line level for the state being entered, so
  // uart_tx comes straight from a flop.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    snap_d  = snap_q;
    prev_d  = prev_q;
    pend_d  = pend_q;
    done_d  = done_q;
    init_d  = init_q;
    start   = 1'b0;

    if (!init_q) begin
      // First edge out of reset only captures the current progress value.
      init_d = 1'b1;
      prev_d = test_progress;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_d = 1'b1;
          if (!done_q) begin
            if (test_fail != 32'd0) begin
              msg_d  = MSG_FAIL;
              snap_d = test_fail;
              done_d = 1'b1;
              start  = 1'b1;
            end else if (test_pass != 32'd0) begin
              msg_d  = MSG_PASS;
              snap_d = test_pass;
              done_d = 1'b1;
              start  = 1'b1;
            end else if (pend_q) begin
              msg_d  = MSG_PROG;
              snap_d = prev_q;
              pend_d = 1'b0;
              start  = 1'b1;
            end
          end
          if (start) begin
            state_d = ST_START;
            cnt_d   = CNT_MAX;
            byte_d  = 4'd0;
            tx_d    = 1'b0;
          end
        end
        ST_START: begin
          if (cnt_q == '0) begin
            state_d = ST_DATA;
            cnt_d   = CNT_MAX;
            bit_d   = 3'd0;
            tx_d    = cur_byte[0];
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            cnt_d = CNT_MAX;
            if (bit_q == 3'd7) begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d = bit_nxt;
              tx_d  = cur_byte[bit_nxt];
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_q == '0) begin
            if (byte_q == LAST_BYTE) begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end else begin
              state_d = ST_START;
              cnt_d   = CNT_MAX;
              byte_d  = byte_q + 4'd1;
              tx_d    = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase

      // A change seen on the launch edge itself is still reported later.
      if (test_progress != prev_q) begin
        prev_d = test_progress;
        pend_d = 1'b1;
      end
      // After PASS/FAIL nothing else is ever reported.
      if (done_d) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      msg_q   <= MSG_PROG;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 4'd0;
      tx_q    <= 1'b1;
      snap_q  <= 32'd0;
      prev_q  <= 32'd0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      snap_q  <= snap_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      init_q  <= init_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule
`default_nettype wire
